// File: rtl/systolic_result_drain_if.sv
// Result stream bundle between the systolic drain and its downstream consumer.
// Latency: none (wires only).
// Backpressure: out_ready from the slave stalls the master; the payload is held while stalled.
// Signals: out_valid/out_data/out_row/out_col/out_last (master -> slave), out_ready (slave -> master).
interface systolic_result_drain_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int IDXW  = $clog2(N)
) ();
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_row;
  logic [IDXW-1:0]  out_col;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Snapshots all N*N accumulator outputs on start, then streams them row-major one word per handshake.
// Latency: element (0,0) is valid in the cycle after the capture edge; done pulses one cycle after the last handshake.
// Backpressure: out_ready low holds the presented word; all outputs are registered state, no ready-to-data path.
// Ports: clock/nreset; start + z_flat (capture side); out_if (result stream); acc_clear, busy, done, overrun (status).
module systolic_result_drain #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int IDXW  = $clog2(N)
) (
  input  logic                      clock,
  input  logic                      nreset,
  input  logic                      start,
  input  logic [N*N*WIDTH-1:0]      z_flat,
  systolic_result_drain_if.master   out_if,
  output logic                      acc_clear,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  localparam int              AW   = $clog2(N*N);
  localparam logic [IDXW-1:0] LAST = IDXW'(N-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  row_q, row_d;
  logic [IDXW-1:0]  col_q, col_d;
  logic             overrun_q, overrun_d;
  logic             acc_clear_q, acc_clear_d;
  logic             capture;
  logic             streaming;
  logic             handshake;
  logic             at_last_col;
  logic             at_last;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] buf_q [N*N];

  assign streaming   = (state_q == S_STREAM);
  assign handshake   = streaming && out_if.out_ready;
  assign at_last_col = (col_q == LAST);
  assign at_last     = at_last_col && (row_q == LAST);
  assign rd_idx      = AW'(row_q) * AW'(N) + AW'(col_q);

  // Outputs are gated by the stream state so that IDLE/DONE (and reset) present all zeros.
  assign out_if.out_valid = streaming;
  assign out_if.out_data  = streaming ? buf_q[rd_idx] : '0;
  assign out_if.out_row   = streaming ? row_q : '0;
  assign out_if.out_col   = streaming ? col_q : '0;
  assign out_if.out_last  = streaming && at_last;
  assign busy             = streaming;
  assign done             = (state_q == S_DONE);
  assign overrun          = overrun_q;
  assign acc_clear        = acc_clear_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    overrun_d   = overrun_q;
    acc_clear_d = 1'b0;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture     = 1'b1;
          row_d       = '0;
          col_d       = '0;
          overrun_d   = 1'b0;
          acc_clear_d = 1'b1;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        // A start here cannot be honoured without corrupting the snapshot; flag it instead.
        if (start) begin
          overrun_d = 1'b1;
        end
        if (handshake) begin
          if (at_last) begin
            row_d   = '0;
            col_d   = '0;
            state_d = S_DONE;
          end else if (at_last_col) begin
            col_d = '0;
            row_d = row_q + IDXW'(1);
          end else begin
            col_d = col_q + IDXW'(1);
          end
        end
      end
      S_DONE: begin
        // start is deliberately not sampled here; a held start is taken on the next IDLE cycle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      overrun_q   <= 1'b0;
      acc_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      overrun_q   <= overrun_d;
      acc_clear_q <= acc_clear_d;
    end
  end

  // Snapshot buffer: contents are only meaningful after a capture, so it carries no reset.
  always_ff @(posedge clock) begin
    if (capture) begin
      for (int i = 0; i < N*N; i++) begin
        buf_q[i] <= z_flat[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule
